fwrisc_mem_pipe: RTL and testbench

Parametrised, pipelined successor to the single-outstanding fwrisc load/store bus unit. It accepts core memory requests (loads, stores, AMOs) through a valid/ready handshake and drives a split address/response external bus. It allows up to MAX_OUTSTANDING in-order transactions, applies byte-lane steering and load sign/zero extension, and detects misaligned accesses. It sits between the fwrisc execute stage and the data-side bus fabric.

---
 rtl/fwrisc_mem_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_fwrisc_mem_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_mem_pipe.sv
// fwrisc_mem_pipe: pipelined load/store bus unit for the fwrisc core.
// Accepts core loads, stores and AMOs over a valid/ready handshake, issues
// them on a split address/response bus with up to MAX_OUTSTANDING in flight,
// and returns in-order acknowledgements with lane steering and extension.
module fwrisc_mem_pipe #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          CHECK_ALIGN     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_op,
    input  logic        req_amo,
    input  logic [31:0] req_data,
    output logic        ack_valid,
    output logic [31:0] ack_data,
    output logic        ack_err,
    output logic        dvalid,
    input  logic        dready,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwstb,
    output logic        dwrite,
    input  logic        drvalid,
    input  logic [31:0] drdata
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    // Memory operation codes shared with the execute stage
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    typedef struct packed {
        logic [3:0] op;
        logic       amo;
        logic [1:0] lsb;
    } entry_t;

    entry_t         queue [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           misaligned;
    logic           is_store;
    logic           accept_aligned;
    logic           accept_err;
    logic           pop;
    logic [3:0]     next_stb;
    logic [31:0]    next_wdata;
    entry_t         head;
    logic [7:0]     head_byte;
    logic [15:0]    head_half;
    logic [31:0]    head_result;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Classify the incoming request: alignment and store/RMW direction
    always_comb begin
        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            if (req_amo) begin
                misaligned = |req_addr[1:0];
            end else begin
                case (req_op)
                    OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
                    OP_LW, OP_SW:         misaligned = |req_addr[1:0];
                    default:              misaligned = 1'b0;
                endcase
            end
        end
        is_store = !req_amo && (req_op == OP_SB || req_op == OP_SH || req_op == OP_SW);
    end

    // Error responses wait for an idle pipe so acks stay in request order
    always_comb begin
        if (misaligned) begin
            req_ready = (count == '0) && !dvalid;
        end else begin
            req_ready = (count < CW'(MAX_OUTSTANDING)) && (!dvalid || dready);
        end
        accept_aligned = req_valid && req_ready && !misaligned;
        accept_err     = req_valid && req_ready && misaligned;
        pop            = drvalid && (count != '0);
    end

    // Byte-lane steering of write data and strobes
    always_comb begin
        next_stb   = '0;
        next_wdata = '0;
        if (req_amo) begin
            next_stb   = '1;
            next_wdata = req_data;
        end else begin
            case (req_op)
                OP_SB: begin
                    next_stb   = 4'b0001 << req_addr[1:0];
                    next_wdata = {4{req_data[7:0]}};
                end
                OP_SH: begin
                    next_stb   = req_addr[1] ? 4'b1100 : 4'b0011;
                    next_wdata = {2{req_data[15:0]}};
                end
                OP_SW: begin
                    next_stb   = '1;
                    next_wdata = req_data;
                end
                default: begin
                    next_stb   = '0;
                    next_wdata = '0;
                end
            endcase
        end
    end

    // Address-phase registers: load on accept, hold while stalled, drop on handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            dvalid <= 1'b0;
            daddr  <= '0;
            dwdata <= '0;
            dwstb  <= '0;
            dwrite <= 1'b0;
        end else if (accept_aligned) begin
            dvalid <= 1'b1;
            daddr  <= req_addr;
            dwdata <= next_wdata;
            dwstb  <= next_stb;
            dwrite <= is_store || req_amo;
        end else if (dvalid && dready) begin
            dvalid <= 1'b0;
            dwstb  <= '0;
        end
    end

    // Response-queue storage; flushed by resetting the pointers only
    always_ff @(posedge clock) begin
        if (accept_aligned) begin
            queue[wr_ptr] <= '{op: req_op, amo: req_amo, lsb: req_addr[1:0]};
        end
    end

    // Queue pointers and outstanding count
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept_aligned) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (accept_aligned && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept_aligned) begin
                count <= count - 1'b1;
            end
        end
    end

    // Format response data according to the head entry's op and lane
    always_comb begin
        head = queue[rd_ptr];
        case (head.lsb)
            2'd0:    head_byte = drdata[7:0];
            2'd1:    head_byte = drdata[15:8];
            2'd2:    head_byte = drdata[23:16];
            default: head_byte = drdata[31:24];
        endcase
        head_half = head.lsb[1] ? drdata[31:16] : drdata[15:0];
        if (head.amo) begin
            head_result = drdata;
        end else begin
            case (head.op)
                OP_LB:                head_result = {{24{head_byte[7]}}, head_byte};
                OP_LBU:               head_result = {24'd0, head_byte};
                OP_LH:                head_result = {{16{head_half[15]}}, head_half};
                OP_LHU:               head_result = {16'd0, head_half};
                OP_SB, OP_SH, OP_SW:  head_result = '0;
                default:              head_result = drdata;
            endcase
        end
    end

    // One-cycle acknowledge pulse for each retired or rejected request
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_valid <= 1'b0;
            ack_data  <= '0;
            ack_err   <= 1'b0;
        end else begin
            ack_valid <= pop || accept_err;
            if (pop) begin
                ack_data <= head_result;
                ack_err  <= 1'b0;
            end else if (accept_err) begin
                ack_data <= '0;
                ack_err  <= 1'b1;
            end else begin
                ack_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_pipe.sv
// Self-checking bench for fwrisc_mem_pipe: directed stimulus with literal
// expectations plus a transaction-level model compared every cycle.
module tb_fwrisc_mem_pipe;

    localparam int unsigned MAXO = 2;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_op = '0;
    logic        req_amo = 1'b0;
    logic [31:0] req_data = '0;
    logic        ack_valid;
    logic [31:0] ack_data;
    logic        ack_err;
    logic        dvalid;
    logic        dready = 1'b1;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic        drvalid = 1'b0;
    logic [31:0] drdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    fwrisc_mem_pipe #(
        .MAX_OUTSTANDING(MAXO),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_amo(req_amo), .req_data(req_data),
        .ack_valid(ack_valid), .ack_data(ack_data), .ack_err(ack_err),
        .dvalid(dvalid), .dready(dready), .daddr(daddr), .dwdata(dwdata),
        .dwstb(dwstb), .dwrite(dwrite), .drvalid(drvalid), .drdata(drdata)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [3:0] op;
        logic       amo;
        logic [1:0] lsb;
    } pend_t;

    pend_t       mq[$];
    bit          mvalid = 1'b0;
    logic        e_dvalid, e_dwrite, e_ack_v, e_ack_e;
    logic [31:0] e_daddr, e_dwdata, e_ack_d;
    logic [3:0]  e_dwstb;

    function automatic logic m_misaligned(input logic [31:0] a, input logic [3:0] op, input logic amo);
        if (amo || op == OP_LW || op == OP_SW) return (a % 4) != 0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_result(input pend_t p, input logic [31:0] rd);
        logic [31:0] sh;
        if (p.amo) return rd;
        sh = rd >> (8 * p.lsb);
        case (p.op)
            OP_LB:  return 32'($signed(sh[7:0]));
            OP_LBU: return 32'(sh[7:0]);
            OP_LH:  begin sh = rd >> (p.lsb[1] ? 16 : 0); return 32'($signed(sh[15:0])); end
            OP_LHU: begin sh = rd >> (p.lsb[1] ? 16 : 0); return 32'(sh[15:0]); end
            OP_LW:  return rd;
            default: return 32'd0;
        endcase
    endfunction

    // Compare DUT against the model, then advance the model by one cycle
    always @(negedge clock) begin
        logic  mis, rdy, acc, popped;
        pend_t h;
        if (mvalid) begin
            chk("ack_valid", 32'(ack_valid), 32'(e_ack_v));
            if (e_ack_v) begin
                chk("ack_data", ack_data, e_ack_d);
                chk("ack_err", 32'(ack_err), 32'(e_ack_e));
            end
            chk("dvalid", 32'(dvalid), 32'(e_dvalid));
            chk("dwstb", 32'(dwstb), 32'(e_dwstb));
            if (e_dvalid) begin
                chk("daddr", daddr, e_daddr);
                chk("dwdata", dwdata, e_dwdata);
                chk("dwrite", 32'(dwrite), 32'(e_dwrite));
            end
        end
        if (reset) begin
            mq.delete();
            {e_dvalid, e_dwrite, e_ack_v, e_ack_e} = '0;
            {e_daddr, e_dwdata, e_ack_d} = '0;
            e_dwstb = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            assert (!(drvalid && mq.size() == 0)) else $error("drvalid with nothing outstanding");
            mis = m_misaligned(req_addr, req_op, req_amo);
            rdy = mis ? (mq.size() == 0 && !e_dvalid)
                      : (mq.size() < MAXO && (!e_dvalid || dready));
            chk("req_ready", 32'(req_ready), 32'(rdy));
            acc = req_valid && rdy;
            popped = drvalid && mq.size() > 0;
            e_ack_v = 1'b0;
            if (popped) begin
                h = mq.pop_front();
                e_ack_v = 1'b1;
                e_ack_e = 1'b0;
                e_ack_d = m_result(h, drdata);
            end
            if (acc && mis) begin
                e_ack_v = 1'b1;
                e_ack_e = 1'b1;
                e_ack_d = 32'd0;
            end
            if (acc && !mis) begin
                mq.push_back('{op: req_op, amo: req_amo, lsb: req_addr[1:0]});
                e_dvalid = 1'b1;
                e_daddr  = req_addr;
                e_dwrite = req_amo || req_op == OP_SB || req_op == OP_SH || req_op == OP_SW;
                if (req_amo || req_op == OP_SW) begin
                    e_dwstb = 4'hF; e_dwdata = req_data;
                end else if (req_op == OP_SH) begin
                    e_dwstb = 4'b0011 << (2 * req_addr[1]);
                    e_dwdata = req_data[15:0] * 32'h0001_0001;
                end else if (req_op == OP_SB) begin
                    e_dwstb = 4'b0001 << req_addr[1:0];
                    e_dwdata = req_data[7:0] * 32'h0101_0101;
                end else begin
                    e_dwstb = 4'h0; e_dwdata = 32'd0;
                end
            end else if (e_dvalid && dready) begin
                e_dvalid = 1'b0;
                e_dwstb  = 4'h0;
            end
            chk("model_count", 32'(mq.size() <= MAXO), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded)
    task automatic send(input logic [31:0] a, input logic [3:0] op, input logic amo, input logic [31:0] d);
        req_valid = 1'b1; req_addr = a; req_op = op; req_amo = amo; req_data = d;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                cyc();
                req_valid = 1'b0;
                return;
            end
            cyc();
        end
        chk("send_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        drvalid = 1'b1; drdata = d;
        cyc();
        drvalid = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_ack_valid", 32'(ack_valid), 32'd0);
        chk("rst_dwstb", 32'(dwstb), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        cyc();

        // LB / LBU sign and zero extension on lane 3
        send(32'h0000_0103, OP_LB, 1'b0, 32'd0);
        chk("t1_daddr", daddr, 32'h0000_0103);
        chk("t1_dwstb", 32'(dwstb), 32'd0);
        chk("t1_dwrite", 32'(dwrite), 32'd0);
        cyc();
        respond(32'h80FF_1234);
        chk("t1_ack_v", 32'(ack_valid), 32'd1);
        chk("t1_lb", ack_data, 32'hFFFF_FF80);
        send(32'h0000_0103, OP_LBU, 1'b0, 32'd0);
        cyc();
        respond(32'h80FF_1234);
        chk("t1_lbu", ack_data, 32'h0000_0080);

        // SH to the upper half
        send(32'h0000_0202, OP_SH, 1'b0, 32'h1234_ABCD);
        chk("t2_dwstb", 32'(dwstb), 32'hC);
        chk("t2_dwdata", dwdata, 32'hABCD_ABCD);
        chk("t2_dwrite", 32'(dwrite), 32'd1);
        cyc();
        respond(32'hDEAD_BEEF);
        chk("t2_ack_v", 32'(ack_valid), 32'd1);
        chk("t2_ack_data", ack_data, 32'd0);
        chk("t2_ack_err", 32'(ack_err), 32'd0);
        cyc();

        // Outstanding limit of two, in-order data return
        send(32'h10, OP_LW, 1'b0, 32'd0);
        send(32'h14, OP_LW, 1'b0, 32'd0);
        req_valid = 1'b1; req_addr = 32'h18; req_op = OP_LW;
        #1;
        chk("t3_block0", 32'(req_ready), 32'd0);
        cyc();
        chk("t3_block1", 32'(req_ready), 32'd0);
        drvalid = 1'b1; drdata = 32'h0000_1010;
        #1;
        chk("t3_block2", 32'(req_ready), 32'd0);
        cyc();
        drvalid = 1'b0;
        chk("t3_ack0", ack_data, 32'h0000_1010);
        #1;
        chk("t3_unblock", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        respond(32'h0000_1414);
        chk("t3_ack1", ack_data, 32'h0000_1414);
        respond(32'h0000_1818);
        chk("t3_ack2", ack_data, 32'h0000_1818);
        cyc();

        // Misaligned LW waits for an empty pipe, then errors without a bus cycle
        send(32'h20, OP_LW, 1'b0, 32'd0);
        req_valid = 1'b1; req_addr = 32'h0000_0101; req_op = OP_LW;
        #1;
        chk("t4_block", 32'(req_ready), 32'd0);
        cyc();
        respond(32'h0000_2020);
        chk("t4_ack_lw", ack_data, 32'h0000_2020);
        #1;
        chk("t4_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("t4_err_v", 32'(ack_valid), 32'd1);
        chk("t4_err", 32'(ack_err), 32'd1);
        chk("t4_err_data", ack_data, 32'd0);
        chk("t4_no_bus", 32'(dvalid), 32'd0);
        cyc();

        // Address-phase stall holds outputs stable
        dready = 1'b0;
        send(32'h40, OP_SW, 1'b0, 32'hCAFE_F00D);
        req_valid = 1'b1; req_addr = 32'h44; req_op = OP_LW;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_dvalid", 32'(dvalid), 32'd1);
            chk("t5_daddr", daddr, 32'h40);
            chk("t5_dwdata", dwdata, 32'hCAFE_F00D);
            chk("t5_dwstb", 32'(dwstb), 32'hF);
            chk("t5_dwrite", 32'(dwrite), 32'd1);
            chk("t5_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        req_valid = 1'b0;
        dready = 1'b1;
        cyc();
        chk("t5_drop", 32'(dvalid), 32'd0);
        chk("t5_drop_stb", 32'(dwstb), 32'd0);
        respond(32'h1111_2222);
        chk("t5_ack", ack_data, 32'd0);
        cyc();

        // Reset with two outstanding drops them; fresh LW has no stale ack
        send(32'h50, OP_LW, 1'b0, 32'd0);
        send(32'h54, OP_LW, 1'b0, 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_dvalid", 32'(dvalid), 32'd0);
        chk("t6_daddr", daddr, 32'd0);
        chk("t6_ack_v", 32'(ack_valid), 32'd0);
        #1;
        chk("t6_ready", 32'(req_ready), 32'd1);
        send(32'h58, OP_LW, 1'b0, 32'd0);
        cyc();
        respond(32'h0000_5858);
        chk("t6_ack", ack_data, 32'h0000_5858);
        cyc();
        chk("t6_no_stale", 32'(ack_valid), 32'd0);

        // AMO returns old value; SB on lane 2
        send(32'h60, OP_LB, 1'b1, 32'h0000_00AA);
        chk("amo_dwstb", 32'(dwstb), 32'hF);
        cyc();
        respond(32'h7654_3210);
        chk("amo_ack", ack_data, 32'h7654_3210);
        send(32'h62, OP_SB, 1'b0, 32'h0000_00A5);
        chk("sb_dwstb", 32'(dwstb), 32'h4);
        chk("sb_dwdata", dwdata, 32'hA5A5_A5A5);
        cyc();
        respond(32'd0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
